// File: rtl/d5m_pkg.sv
// Shared types and constants for the D5M sensor emulator and capture path.
package d5m_pkg;

   localparam int unsigned D5M_COLS  = 2592;
   localparam int unsigned D5M_LINES = 1944;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FOT    = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_HBLANK = 3'd3,
      ST_VBLANK = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      PAT_INC = 2'd0,
      PAT_COL = 2'd1,
      PAT_ROW = 2'd2,
      PAT_CHK = 2'd3
   } pattern_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/d5m_pattern_gen.sv
// Combinational test-pattern pixel value from pattern code and frame position.
module d5m_pattern_gen
   import d5m_pkg::*;
#(
   parameter int unsigned COL_W = 12,
   parameter int unsigned ROW_W = 11,
   parameter int unsigned PIX_W = 23
) (
   input  logic [1:0]       pattern,
   input  logic [COL_W-1:0] col,
   input  logic [ROW_W-1:0] row,
   input  logic [PIX_W-1:0] pix,
   output logic [7:0]       pixel
);

   logic [7:0] col8;
   logic [7:0] row8;
   logic [7:0] pix8;

   // Truncate/extend positions to 8 bits, then select the pattern.
   always_comb begin
      col8  = 8'(col);
      row8  = 8'(row);
      pix8  = 8'(pix);
      pixel = 8'h00;
      unique case (pattern_e'(pattern))
         PAT_INC: pixel = pix8;
         PAT_COL: pixel = col8;
         PAT_ROW: pixel = row8;
         PAT_CHK: pixel = {8{col8[3] ^ row8[3]}};
         default: pixel = 8'h00;
      endcase
   end

endmodule

// File: rtl/d5m_sensor_emulator.sv
// Synthetic D5M sensor: FVAL/LVAL/data framing with programmable geometry and patterns.
module d5m_sensor_emulator
   import d5m_pkg::*;
#(
   parameter int unsigned COLS       = D5M_COLS,
   parameter int unsigned LINES      = D5M_LINES,
   parameter int unsigned FOT_CYCLES = 8,
   parameter int unsigned H_BLANK    = 16,
   parameter int unsigned V_BLANK    = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trigger,
   input  logic        continuous,
   input  logic [1:0]  pattern_sel,
   output logic        frame_valid,
   output logic        line_valid,
   output logic [7:0]  data_out,
   output logic [15:0] frame_count,
   output logic        busy
);

   localparam int unsigned COL_W = cnt_width(COLS);
   localparam int unsigned ROW_W = cnt_width(LINES);
   localparam int unsigned PIX_W = cnt_width(COLS * LINES);
   localparam int unsigned BLK_W = cnt_width(max3(FOT_CYCLES, H_BLANK, V_BLANK));

   state_e             state_q, state_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [PIX_W-1:0]   pix_q, pix_d;
   logic [BLK_W-1:0]   blk_q, blk_d;
   logic [1:0]         pat_q, pat_d;
   logic [15:0]        fcnt_q, fcnt_d;
   logic               fv_c, lv_c, busy_c;
   logic [7:0]         data_c, pixel_c;

   // Pixel value for the position that will be on the bus after this edge.
   d5m_pattern_gen #(
      .COL_W (COL_W),
      .ROW_W (ROW_W),
      .PIX_W (PIX_W)
   ) u_pattern_gen (
      .pattern (pat_d),
      .col     (col_d),
      .row     (row_d),
      .pix     (pix_d),
      .pixel   (pixel_c)
   );

   // Next-state, counters and next output values.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      pix_d   = pix_q;
      blk_d   = blk_q;
      pat_d   = pat_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (trigger || continuous) begin
               state_d = ST_FOT;
               col_d   = '0;
               row_d   = '0;
               pix_d   = '0;
               blk_d   = '0;
               pat_d   = pattern_sel;
            end
         end
         ST_FOT: begin
            if (blk_q == BLK_W'(FOT_CYCLES - 1)) begin
               state_d = ST_ACTIVE;
               blk_d   = '0;
            end else begin
               blk_d = blk_q + BLK_W'(1);
            end
         end
         ST_ACTIVE: begin
            pix_d = pix_q + PIX_W'(1);
            if (col_q == COL_W'(COLS - 1)) begin
               col_d = '0;
               blk_d = '0;
               if (row_q == ROW_W'(LINES - 1)) begin
                  state_d = ST_VBLANK;
                  fcnt_d  = fcnt_q + 16'd1;
               end else begin
                  state_d = ST_HBLANK;
               end
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         ST_HBLANK: begin
            if (blk_q == BLK_W'(H_BLANK - 1)) begin
               state_d = ST_ACTIVE;
               row_d   = row_q + ROW_W'(1);
               blk_d   = '0;
            end else begin
               blk_d = blk_q + BLK_W'(1);
            end
         end
         ST_VBLANK: begin
            if (blk_q == BLK_W'(V_BLANK - 1)) begin
               blk_d = '0;
               if (continuous) begin
                  state_d = ST_FOT;
                  col_d   = '0;
                  row_d   = '0;
                  pix_d   = '0;
                  pat_d   = pattern_sel;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               blk_d = blk_q + BLK_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      fv_c   = (state_d == ST_FOT) || (state_d == ST_ACTIVE) || (state_d == ST_HBLANK);
      lv_c   = (state_d == ST_ACTIVE);
      busy_c = (state_d != ST_IDLE);
      data_c = lv_c ? pixel_c : 8'h00;
   end

   // State, counters and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         pix_q       <= '0;
         blk_q       <= '0;
         pat_q       <= '0;
         fcnt_q      <= '0;
         frame_valid <= 1'b0;
         line_valid  <= 1'b0;
         data_out    <= 8'h00;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         pix_q       <= pix_d;
         blk_q       <= blk_d;
         pat_q       <= pat_d;
         fcnt_q      <= fcnt_d;
         frame_valid <= fv_c;
         line_valid  <= lv_c;
         data_out    <= data_c;
         busy        <= busy_c;
      end
   end

   assign frame_count = fcnt_q;

endmodule

// File: tb/tb_d5m_sensor_emulator.sv
// Bench for d5m_sensor_emulator: directed scenarios plus random control against a frame-timeline model.
module tb_d5m_sensor_emulator;

   localparam int C  = 4;
   localparam int L  = 3;
   localparam int F  = 2;
   localparam int H  = 3;
   localparam int V  = 5;
   localparam int C2 = 16;
   localparam int L2 = 9;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger, continuous;
   logic [1:0]  pattern_sel;
   logic        frame_valid, line_valid, busy;
   logic [7:0]  data_out;
   logic [15:0] frame_count;

   logic        trig2, cont2;
   logic [1:0]  pat2;
   logic        fv2, lv2, busy2;
   logic [7:0]  data2;
   logic [15:0] fc2;

   int total = 0;
   int bad   = 0;

   // model state per instance: idle flag, cycle offset in frame, latched pattern, frame count
   bit ma_idle = 1'b1;
   int ma_t = 0, ma_pat = 0, ma_fc = 0;
   bit mb_idle = 1'b1;
   int mb_t = 0, mb_pat = 0, mb_fc = 0;

   always #5 clk = ~clk;

   d5m_sensor_emulator #(
      .COLS(C), .LINES(L), .FOT_CYCLES(F), .H_BLANK(H), .V_BLANK(V)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .trigger     (trigger),
      .continuous  (continuous),
      .pattern_sel (pattern_sel),
      .frame_valid (frame_valid),
      .line_valid  (line_valid),
      .data_out    (data_out),
      .frame_count (frame_count),
      .busy        (busy)
   );

   d5m_sensor_emulator #(
      .COLS(C2), .LINES(L2), .FOT_CYCLES(F), .H_BLANK(H), .V_BLANK(V)
   ) u_dut_wide (
      .clk         (clk),
      .rst         (rst),
      .trigger     (trig2),
      .continuous  (cont2),
      .pattern_sel (pat2),
      .frame_valid (fv2),
      .line_valid  (lv2),
      .data_out    (data2),
      .frame_count (fc2),
      .busy        (busy2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected {busy, fv, lv, data} from the frame timeline position.
   function automatic logic [10:0] expect_out(input bit idle, input int t, input int pat,
                                             input int c, input int l, input int f, input int h);
      int a, u, row, w, pix, val;
      if (idle) return 11'd0;
      if (t < f) return {1'b1, 1'b1, 1'b0, 8'h00};
      a = l * c + (l - 1) * h;
      if (t >= f + a) return {1'b1, 1'b0, 1'b0, 8'h00};
      u   = t - f;
      row = u / (c + h);
      w   = u % (c + h);
      if (w >= c) return {1'b1, 1'b1, 1'b0, 8'h00};
      pix = row * c + w;
      case (pat)
         0:       val = pix % 256;
         1:       val = w % 256;
         2:       val = row % 256;
         default: val = (((w / 8) ^ (row / 8)) % 2 == 1) ? 255 : 0;
      endcase
      return {1'b1, 1'b1, 1'b1, 8'(val)};
   endfunction

   // Advance one instance's model by one clock edge.
   task automatic model_step(input bit r, input bit trig, input bit cont, input int sel,
                             input int c, input int l, input int f, input int h, input int v,
                             inout bit idle, inout int t, inout int pat, inout int fc);
      int a, period;
      a = l * c + (l - 1) * h;
      period = f + a + v;
      if (r) begin
         idle = 1'b1;
         t    = 0;
         fc   = 0;
      end else if (idle) begin
         if (trig || cont) begin
            idle = 1'b0;
            t    = 0;
            pat  = sel;
         end
      end else begin
         t++;
         if (t == f + a) fc = (fc + 1) % 65536;
         if (t == period) begin
            if (cont) begin
               t   = 0;
               pat = sel;
            end else begin
               idle = 1'b1;
               t    = 0;
            end
         end
      end
   endtask

   task automatic tick(input string tag);
      logic [10:0] e;
      @(posedge clk);
      model_step(rst, trigger, continuous, int'(pattern_sel), C, L, F, H, V,
                 ma_idle, ma_t, ma_pat, ma_fc);
      model_step(rst, trig2, cont2, int'(pat2), C2, L2, F, H, V,
                 mb_idle, mb_t, mb_pat, mb_fc);
      #1;
      e = expect_out(ma_idle, ma_t, ma_pat, C, L, F, H);
      check({tag, "_out"}, 32'({busy, frame_valid, line_valid, data_out}), 32'(e));
      check({tag, "_fc"}, 32'(frame_count), 32'(ma_fc));
      e = expect_out(mb_idle, mb_t, mb_pat, C2, L2, F, H);
      check({tag, "_wide_out"}, 32'({busy2, fv2, lv2, data2}), 32'(e));
      check({tag, "_wide_fc"}, 32'(fc2), 32'(mb_fc));
   endtask

   task automatic run(input int n, input string tag);
      repeat (n) tick(tag);
   endtask

   initial begin
      rst = 1'b1;
      trigger = 1'b0; continuous = 1'b0; pattern_sel = 2'd0;
      trig2 = 1'b0;   cont2 = 1'b0;      pat2 = 2'd3;
      run(3, "reset");
      rst = 1'b0;
      run(2, "idle");

      // start a frame, reset it in row 1 while frame_count is still 0
      trigger = 1'b1; trig2 = 1'b1;
      tick("start");
      trigger = 1'b0; trig2 = 1'b0;
      run(9, "pre_rst");
      check("in_row1", 32'(line_valid), 32'd1);
      rst = 1'b1;
      tick("mid_rst");
      check("mid_rst_fv", 32'(frame_valid), 32'd0);
      rst = 1'b0;
      run(3, "post_rst");

      // clean single frame, pattern 0; checkerboard on the wide instance
      pattern_sel = 2'd0; pat2 = 2'd3;
      trigger = 1'b1; trig2 = 1'b1;
      tick("single");
      trigger = 1'b0; trig2 = 1'b0;
      run(240, "single");
      check("single_fc", 32'(frame_count), 32'd1);
      check("single_idle", 32'(busy), 32'd0);

      // continuous column ramp, three frames
      pattern_sel = 2'd1; continuous = 1'b1;
      run(75, "cont");
      continuous = 1'b0;
      run(30, "cont_end");
      check("cont_fc", 32'(frame_count), 32'd4);

      // row ramp, then checkerboard, with trigger pulses and pattern changes mid-frame
      for (int p = 2; p < 4; p++) begin
         pattern_sel = 2'(p); pat2 = 2'(p - 2);
         trigger = 1'b1; trig2 = 1'b1;
         tick("rowchk");
         trigger = 1'b0; trig2 = 1'b0;
         run(6, "rowchk");
         trigger = 1'b1; trig2 = 1'b1; pattern_sel = 2'd0; pat2 = 2'd1;
         tick("ignored_trig");
         trigger = 1'b0; trig2 = 1'b0;
         run(240, "rowchk_tail");
      end

      // random control
      for (int i = 0; i < 2500; i++) begin
         trigger     = ($urandom_range(0, 15) == 0);
         trig2       = ($urandom_range(0, 15) == 0);
         pattern_sel = 2'($urandom_range(0, 3));
         pat2        = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 79) == 0) continuous = ~continuous;
         if ($urandom_range(0, 199) == 0) cont2 = ~cont2;
         tick("rand");
      end

      continuous = 1'b0; cont2 = 1'b0; trigger = 1'b0; trig2 = 1'b0;
      run(400, "drain");
      check("drain_idle", 32'({busy, busy2}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
